ones_comp_accumulator: RTL and testbench

ONES_COMP_ACCUMULATOR -- requirements
Module: ones_comp_accumulator

---
 rtl/ones_comp_accumulator.sv | 88 ++++++++
 tb/tb_ones_comp_accumulator.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ones_comp_accumulator.sv
// Ones'-complement accumulator with a deferred end-around carry.
// Words stream in during ACCUM, and the carry is kept in a separate bit
// instead of being folded back on every add. A single FOLD cycle adds that
// carry back in. The result is then held in DONE until the consumer takes it.
module ones_comp_accumulator #(
  parameter int WIDTH     = 16,
  parameter int COUNT_W   = 8,
  parameter int ZERO_NORM = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   sum,
  output logic [WIDTH-1:0]   checksum,
  output logic [COUNT_W-1:0] word_count
);

  typedef enum logic [1:0] {IDLE, ACCUM, FOLD, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   acc;
  logic               carry;
  logic [COUNT_W-1:0] cnt;
  logic               accept;
  logic [WIDTH:0]     add_res;

  assign accept  = in_valid & in_ready;
  // The carry from the previous add joins the next add. {carry, acc} can
  // never be {1, all ones}, so the later fold can never overflow again.
  assign add_res = {1'b0, acc} + {1'b0, in_data} + {{WIDTH{1'b0}}, carry};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start)                state_nxt = ACCUM;
      ACCUM: if (accept && in_last)    state_nxt = FOLD;
      FOLD:                            state_nxt = DONE;
      DONE:  if (out_ready)            state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // Accumulator, deferred carry and saturating word counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc   <= '0;
          carry <= 1'b0;
          cnt   <= '0;
        end
        ACCUM: if (accept) begin
          {carry, acc} <= add_res;
          if (cnt != {COUNT_W{1'b1}}) cnt <= cnt + COUNT_W'(1);
        end
        FOLD: begin
          acc   <= acc + WIDTH'(carry);
          carry <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (state == ACCUM);
  assign out_valid  = (state == DONE);
  assign sum        = ((ZERO_NORM != 0) && (&acc)) ? '0 : acc;
  assign checksum   = ~acc;
  assign word_count = cnt;

endmodule

// File: tb/tb_ones_comp_accumulator.sv
// Bench for ones_comp_accumulator. Five instances of different widths share
// one input stream, so they all run with the same handshake timing. Results
// are checked against a plain arithmetic ones'-complement sum and a small
// table of hand-derived vectors.
module tb_ones_comp_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [63:0] in_data = '0;

  logic        rdy4, rdy4z, rdy8, rdy16, rdy32;
  logic        ov4, ov4z, ov8, ov16, ov32;
  logic [3:0]  s4, c4, s4z, c4z;
  logic [7:0]  s8, c8;
  logic [15:0] s16, c16;
  logic [31:0] s32, c32;
  logic [7:0]  n4, n4z, n8, n16, n32;

  int n_cmp = 0, n_bad = 0;
  logic [63:0] words[$];

  always #5 clk = ~clk;

  ones_comp_accumulator #(.WIDTH(4), .COUNT_W(8), .ZERO_NORM(0)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy4),
    .in_data(in_data[3:0]), .in_last(in_last), .out_valid(ov4), .out_ready(out_ready),
    .sum(s4), .checksum(c4), .word_count(n4));
  ones_comp_accumulator #(.WIDTH(4), .COUNT_W(8), .ZERO_NORM(1)) u4z (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy4z),
    .in_data(in_data[3:0]), .in_last(in_last), .out_valid(ov4z), .out_ready(out_ready),
    .sum(s4z), .checksum(c4z), .word_count(n4z));
  ones_comp_accumulator #(.WIDTH(8), .COUNT_W(8), .ZERO_NORM(0)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy8),
    .in_data(in_data[7:0]), .in_last(in_last), .out_valid(ov8), .out_ready(out_ready),
    .sum(s8), .checksum(c8), .word_count(n8));
  ones_comp_accumulator #(.WIDTH(16), .COUNT_W(8), .ZERO_NORM(0)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy16),
    .in_data(in_data[15:0]), .in_last(in_last), .out_valid(ov16), .out_ready(out_ready),
    .sum(s16), .checksum(c16), .word_count(n16));
  ones_comp_accumulator #(.WIDTH(32), .COUNT_W(8), .ZERO_NORM(0)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy32),
    .in_data(in_data[31:0]), .in_last(in_last), .out_valid(ov32), .out_ready(out_ready),
    .sum(s32), .checksum(c32), .word_count(n32));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Ones'-complement sum of the recorded words at width w: add everything
  // as plain integers, then fold the overflow back until it fits.
  function automatic logic [63:0] model(input int w);
    logic [63:0] mask = (64'h1 << w) - 64'h1;
    logic [63:0] t = '0;
    foreach (words[i]) t += words[i] & mask;
    while ((t >> w) != 0) t = (t & mask) + (t >> w);
    return t;
  endfunction

  function automatic logic [63:0] exp_cnt();
    return (words.size() > 255) ? 64'd255 : 64'(words.size());
  endfunction

  // Handshake: in_ready and out_valid are never high together
  always @(negedge clk) if (rst_n) chk("rdy_vs_valid_overlap", {63'd0, rdy16 & ov16}, 64'd0);

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic begin_acc();
    words.delete();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_in_ready", {63'd0, rdy16}, 64'd1);
    chk("start_cnt_clear", {56'd0, n16}, 64'd0);
  endtask

  task automatic push(input logic [63:0] d, input logic l);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!rdy16 && t < 20) begin cyc(); t++; end
    if (!rdy16) chk("push_timeout", 64'd0, 64'd1);
    cyc();
    words.push_back(d);
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    if (l) begin
      chk("fold_no_valid", {63'd0, ov16}, 64'd0);
      cyc();
      chk("latency_valid", {63'd0, ov16}, 64'd1);
    end
  endtask

  // Check every instance against the model while it sits in DONE
  task automatic check_done(input string tag);
    logic [63:0] e4, e8, e16, e32, e4z;
    int t = 0;
    while (!ov16 && t < 10) begin cyc(); t++; end
    e4 = model(4); e8 = model(8); e16 = model(16); e32 = model(32);
    e4z = (e4 == 64'hF) ? 64'd0 : e4;
    chk({tag, "_ov"}, {59'd0, ov4, ov4z, ov8, ov16, ov32}, 64'h1F);
    chk({tag, "_s4"}, 64'(s4), e4);
    chk({tag, "_s4z"}, 64'(s4z), e4z);
    chk({tag, "_c4z"}, 64'(c4z), ~e4 & 64'hF);
    chk({tag, "_s8"}, 64'(s8), e8);
    chk({tag, "_c8"}, 64'(c8), ~e8 & 64'hFF);
    chk({tag, "_s16"}, 64'(s16), e16);
    chk({tag, "_c16"}, 64'(c16), ~e16 & 64'hFFFF);
    chk({tag, "_s32"}, 64'(s32), e32);
    chk({tag, "_c32"}, 64'(c32), ~e32 & 64'hFFFF_FFFF);
    chk({tag, "_cnt"}, 64'(n16), exp_cnt());
    chk({tag, "_cnt4"}, 64'(n4), exp_cnt());
    chk({tag, "_carry"}, {59'd0, u4.carry, u4z.carry, u8.carry, u16.carry, u32.carry}, 64'd0);
  endtask

  // Optionally stall the consumer while pulsing start and junk input data,
  // then complete the handshake and confirm the return to IDLE.
  task automatic release_done(input int hold, input string tag);
    logic [63:0] e16 = model(16);
    logic [63:0] e4 = model(4);
    for (int k = 0; k < hold; k++) begin
      start = k[0]; in_valid = 1'b1; in_data = {$urandom, $urandom};
      cyc();
      chk({tag, "_hold_ov"}, {63'd0, ov16}, 64'd1);
      chk({tag, "_hold_s16"}, 64'(s16), e16);
      chk({tag, "_hold_c4"}, 64'(c4), ~e4 & 64'hF);
      chk({tag, "_hold_cnt"}, 64'(n16), exp_cnt());
    end
    start = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk({tag, "_idle"}, {62'd0, ov16, rdy16}, 64'd0);
  endtask

  typedef struct {
    int              n;
    logic [0:8][15:0] w;
    logic [3:0]      s4, s4z, c4;
    logic [15:0]     s16, c16;
    int              cnt;
    int              hold;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{n:2, w:{16'hA, 16'h7, {7{16'h0}}},
               s4:4'h2, s4z:4'h2, c4:4'hD, s16:16'h0011, c16:16'hFFEE, cnt:2, hold:0};
    tbl[1] = '{n:2, w:{16'h5, 16'hA, {7{16'h0}}},
               s4:4'hF, s4z:4'h0, c4:4'h0, s16:16'h000F, c16:16'hFFF0, cnt:2, hold:0};
    tbl[2] = '{n:9, w:{16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011,
                       16'hC0A8, 16'h0001, 16'hC0A8, 16'h00C7},
               s4:4'hD, s4z:4'hD, c4:4'h2, s16:16'h479E, c16:16'hB861, cnt:9, hold:5};
    tbl[3] = '{n:1, w:{16'h1, {8{16'h0}}},
               s4:4'h1, s4z:4'h1, c4:4'hE, s16:16'h0001, c16:16'hFFFE, cnt:1, hold:0};
    tbl[4] = '{n:2, w:{16'hF, 16'hF, {7{16'h0}}},
               s4:4'hF, s4z:4'h0, c4:4'h0, s16:16'h001E, c16:16'hFFE1, cnt:2, hold:0};

    // Reset state
    cyc(); cyc();
    chk("rst_ready_valid", {62'd0, rdy16, ov16}, 64'd0);
    chk("rst_s16", 64'(s16), 64'd0);
    chk("rst_c16", 64'(c16), 64'hFFFF);
    chk("rst_c4", 64'(c4), 64'hF);
    chk("rst_cnt", 64'(n16), 64'd0);
    rst_n = 1'b1;
    cyc(); cyc();
    chk("post_rst_idle", {62'd0, rdy16, ov16}, 64'd0);

    // Directed table
    for (int i = 0; i < 5; i++) begin
      begin_acc();
      for (int j = 0; j < tbl[i].n; j++) push(64'(tbl[i].w[j]), j == tbl[i].n - 1);
      check_done($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_tbl_s4", i), 64'(s4), 64'(tbl[i].s4));
      chk($sformatf("vec%0d_tbl_s4z", i), 64'(s4z), 64'(tbl[i].s4z));
      chk($sformatf("vec%0d_tbl_c4", i), 64'(c4), 64'(tbl[i].c4));
      chk($sformatf("vec%0d_tbl_c4z", i), 64'(c4z), 64'(tbl[i].c4));
      chk($sformatf("vec%0d_tbl_s16", i), 64'(s16), 64'(tbl[i].s16));
      chk($sformatf("vec%0d_tbl_c16", i), 64'(c16), 64'(tbl[i].c16));
      chk($sformatf("vec%0d_tbl_cnt", i), 64'(n16), 64'(tbl[i].cnt));
      release_done(tbl[i].hold, $sformatf("vec%0d", i));
    end

    // Asynchronous reset mid-ACCUM after three words
    begin_acc();
    push(64'h3, 1'b0); push(64'h5, 1'b0); push(64'h9, 1'b0);
    chk("pre_rst_cnt", 64'(n16), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ready_valid", {62'd0, rdy16, ov16}, 64'd0);
    chk("async_rst_s16", 64'(s16), 64'd0);
    chk("async_rst_c16", 64'(c16), 64'hFFFF);
    chk("async_rst_cnt", 64'(n16), 64'd0);
    cyc();
    rst_n = 1'b1;
    repeat (3) begin
      cyc();
      chk("rst_stay_idle", {62'd0, rdy16, ov16}, 64'd0);
    end
    begin_acc();
    push(64'h1, 1'b1);
    check_done("after_rst");
    chk("after_rst_s16", 64'(s16), 64'd1);
    release_done(0, "after_rst");

    // Counter saturation
    begin_acc();
    for (int j = 0; j < 260; j++) push(64'h1, j == 259);
    check_done("sat");
    chk("sat_cnt_max", 64'(n16), 64'd255);
    release_done(0, "sat");

    // Random streams with input gaps and stray start pulses
    for (int it = 0; it < 30; it++) begin
      int n = $urandom_range(1, 20);
      begin_acc();
      for (int j = 0; j < n; j++) begin
        int g = $urandom_range(0, 2);
        repeat (g) begin
          in_valid = 1'b0; start = 1'($urandom_range(0, 1)); in_data = {$urandom, $urandom};
          cyc();
        end
        start = 1'b0;
        push({$urandom, $urandom}, j == n - 1);
      end
      check_done($sformatf("rnd%0d", it));
      release_done(it % 3, $sformatf("rnd%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
